// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared encodings for the debug dump transmitter
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ARM   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC  = 2'd0,
        SEC_REG = 2'd1,
        SEC_MEM = 2'd2
    } section_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_UART_WIDTH = 8;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / DEFAULT_UART_WIDTH;

    // Number of UART bytes needed to carry one machine word.
    function automatic int bytes_per_word(input int data_width, input int uart_width);
        return data_width / uart_width;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - splits one captured word into UART bytes, LSB first
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_load,
    input  logic [DATA_WIDTH-1:0]      i_load_data,
    input  logic                       i_arm,
    input  logic                       i_wait,
    input  logic                       i_tx_available,
    input  logic                       i_tx_done,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    output logic                       o_fire,
    output logic                       o_byte_sent,
    output logic                       o_word_sent
);

    localparam int BPW = bytes_per_word(DATA_WIDTH, DATA_WIDTH_UART);
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

    logic [DATA_WIDTH-1:0] word_reg;
    logic [BCW-1:0]        byte_cnt;
    logic                  last_byte;

    // The UART is only kicked when it reports idle; i_tx_done counts only while waiting on our own byte.
    assign last_byte   = (byte_cnt == LAST_BYTE);
    assign o_fire      = i_arm & i_tx_available;
    assign o_byte_sent = i_wait & i_tx_done;
    assign o_word_sent = o_byte_sent & last_byte;

    // Word capture, byte pointer advance and the registered one-cycle UART start pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            word_reg    <= '0;
            byte_cnt    <= '0;
            o_tx_signal <= 1'b0;
            o_tx_byte   <= '0;
        end else begin
            o_tx_signal <= 1'b0;
            if (i_load) begin
                word_reg <= i_load_data;
                byte_cnt <= '0;
            end else if (o_byte_sent) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            end
            if (o_fire) begin
                o_tx_signal <= 1'b1;
                o_tx_byte   <= word_reg[byte_cnt*DATA_WIDTH_UART +: DATA_WIDTH_UART];
            end
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// rtl/debug_dump_tx.sv - streams PC, register file and data memory out over the UART on halt
module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int NB_REGS         = 32,
    parameter int NB_MEM          = 32,
    parameter int ADDR_WIDTH      = 5
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic [ADDR_WIDTH-1:0]      o_reg_addr,
    input  logic [DATA_WIDTH-1:0]      i_reg_data,
    output logic [ADDR_WIDTH-1:0]      o_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    input  logic                       i_tx_available,
    input  logic                       i_tx_done,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    output logic                       o_busy,
    output logic                       o_done
);

    // One extra bit so the compare against the last index never wraps.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_REG = CW'(NB_REGS - 1);
    localparam logic [CW-1:0] LAST_MEM = CW'(NB_MEM - 1);

    state_t                state;
    section_t              section;
    logic [CW-1:0]         word_cnt;
    logic [CW-1:0]         word_cnt_inc;
    logic                  start_q;
    logic                  start_rise;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  fire;
    logic                  byte_sent;
    logic                  word_sent;

    assign start_rise   = i_start & ~start_q;
    assign word_cnt_inc = word_cnt + 1'b1;

    // PC is latched on accept; register/memory words are latched in LOAD, one cycle after the address.
    assign load_en   = ((state == ST_IDLE) && start_rise) || (state == ST_LOAD);
    assign load_data = (state == ST_IDLE)    ? i_pc       :
                       (section == SEC_REG)  ? i_reg_data : i_mem_data;

    debug_word_serializer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DATA_WIDTH_UART (DATA_WIDTH_UART)
    ) u_serializer (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_load         (load_en),
        .i_load_data    (load_data),
        .i_arm          (state == ST_ARM),
        .i_wait         (state == ST_WAIT),
        .i_tx_available (i_tx_available),
        .i_tx_done      (i_tx_done),
        .o_tx_signal    (o_tx_signal),
        .o_tx_byte      (o_tx_byte),
        .o_fire         (fire),
        .o_byte_sent    (byte_sent),
        .o_word_sent    (word_sent)
    );

    // Section sequencer: PC, then registers, then memory; addresses stay put for the whole word.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            section    <= SEC_PC;
            word_cnt   <= '0;
            start_q    <= 1'b0;
            o_reg_addr <= '0;
            o_mem_addr <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            start_q <= i_start;
            o_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        section  <= SEC_PC;
                        word_cnt <= '0;
                        o_busy   <= 1'b1;
                        state    <= ST_ARM;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD:  state <= ST_ARM;
                ST_ARM: begin
                    if (fire) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (word_sent)      state <= ST_NEXT;
                    else if (byte_sent) state <= ST_ARM;
                end
                ST_NEXT: begin
                    case (section)
                        SEC_PC: begin
                            section    <= SEC_REG;
                            word_cnt   <= '0;
                            o_reg_addr <= '0;
                            state      <= ST_FETCH;
                        end
                        SEC_REG: begin
                            if (word_cnt < LAST_REG) begin
                                word_cnt   <= word_cnt_inc;
                                o_reg_addr <= word_cnt_inc[ADDR_WIDTH-1:0];
                            end else begin
                                section    <= SEC_MEM;
                                word_cnt   <= '0;
                                o_mem_addr <= '0;
                            end
                            state <= ST_FETCH;
                        end
                        default: begin
                            if (word_cnt < LAST_MEM) begin
                                word_cnt   <= word_cnt_inc;
                                o_mem_addr <= word_cnt_inc[ADDR_WIDTH-1:0];
                                state      <= ST_FETCH;
                            end else begin
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                                state  <= ST_DONE;
                            end
                        end
                    endcase
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb/tb_debug_dump_tx.sv - self-checking bench for debug_dump_tx
module tb_debug_dump_tx;

    localparam int NREG  = 32;
    localparam int NMEM  = 32;
    localparam int TOTAL = (1 + NREG + NMEM) * 4;
    localparam int LIMIT = 8000;

    logic        i_clock, i_reset, i_start;
    logic [31:0] i_pc;
    logic [4:0]  o_reg_addr, o_mem_addr;
    logic [31:0] i_reg_data, i_mem_data;
    logic        i_tx_available, i_tx_done;
    logic        o_tx_signal;
    logic [7:0]  o_tx_byte;
    logic        o_busy, o_done;

    logic [31:0] reg_model [NREG];
    logic [31:0] mem_model [NMEM];
    logic [31:0] mem_q;

    logic uart_avail, uart_done, spur_done, spur_force, spur_en, hold_off;
    int   uart_cnt, spur_ofs, spur_count;
    int   n_pulses, n_done, n_completed;
    int   addr_err, seq_err, stable_err, proto_err;
    logic [7:0] cur_byte;
    logic [4:0] last_mem_addr;
    logic       avail_seen;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    int checks = 0;
    int failures = 0;

    debug_dump_tx dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_pc           (i_pc),
        .o_reg_addr     (o_reg_addr),
        .i_reg_data     (i_reg_data),
        .o_mem_addr     (o_mem_addr),
        .i_mem_data     (i_mem_data),
        .i_tx_available (i_tx_available),
        .i_tx_done      (i_tx_done),
        .o_tx_signal    (o_tx_signal),
        .o_tx_byte      (o_tx_byte),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Register file reads combinationally; data memory answers one cycle after the address.
    assign i_reg_data = reg_model[o_reg_addr];
    always @(posedge i_clock) mem_q <= mem_model[o_mem_addr];
    assign i_mem_data = mem_q;

    assign i_tx_available = uart_avail & ~hold_off;
    assign i_tx_done      = uart_done | spur_done | spur_force;

    // UART model and stream monitor, sampled 1 time unit after each rising edge.
    initial begin
        uart_avail = 1'b1; uart_done = 1'b0; spur_done = 1'b0;
        uart_cnt = 0; spur_ofs = 0; spur_count = 0;
        last_mem_addr = '0; cur_byte = '0;
        forever begin
            @(posedge i_clock);
            #1;
            avail_seen = i_tx_available;
            uart_done = 1'b0;
            spur_done = 1'b0;
            if (spur_ofs > 0) begin
                spur_ofs++;
                if (spur_ofs >= 3) begin
                    spur_done = 1'b1;
                    spur_count++;
                end
                if (spur_ofs == 4) spur_ofs = 0;
            end
            if (o_done === 1'b1) n_done++;
            if (i_reset !== 1'b1 && o_mem_addr !== last_mem_addr && (n_pulses % 4) != 0) addr_err++;
            last_mem_addr = o_mem_addr;
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    if (o_tx_byte !== cur_byte) stable_err++;
                    uart_done = 1'b1;
                    uart_avail = 1'b1;
                    n_completed++;
                    if (spur_en && (n_completed % 4) == 0) spur_ofs = 1;
                end
            end
            if (o_tx_signal === 1'b1) begin
                if (avail_seen !== 1'b1) proto_err++;
                if (n_pulses >= 4 && n_pulses < 4 * (1 + NREG)) begin
                    if (o_reg_addr !== 5'(n_pulses / 4 - 1)) seq_err++;
                end else if (n_pulses >= 4 * (1 + NREG)) begin
                    if (o_mem_addr !== 5'(n_pulses / 4 - 1 - NREG)) seq_err++;
                end
                cur_byte = o_tx_byte;
                got_q.push_back(o_tx_byte);
                n_pulses++;
                uart_cnt = 10;
                uart_avail = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #2;
    endtask

    task automatic clear_stats();
        n_pulses = 0; n_done = 0; n_completed = 0;
        addr_err = 0; seq_err = 0; stable_err = 0; proto_err = 0;
        spur_count = 0;
        got_q.delete();
    endtask

    task automatic randomize_state();
        i_pc = $urandom;
        for (int i = 0; i < NREG; i++) reg_model[i] = $urandom;
        for (int i = 0; i < NMEM; i++) mem_model[i] = $urandom;
    endtask

    // Reference stream: PC, registers, memory, each word least significant byte first.
    task automatic build_expected();
        logic [31:0] w;
        exp_q.delete();
        for (int k = 0; k < 1 + NREG + NMEM; k++) begin
            if (k == 0)          w = i_pc;
            else if (k <= NREG)  w = reg_model[k - 1];
            else                 w = mem_model[k - 1 - NREG];
            for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
        end
    endtask

    function automatic int stream_errors();
        int e;
        e = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < LIMIT && n_done == 0; i++) tick();
        ok = (n_done != 0);
    endtask

    task automatic wait_pulses(input int n, output bit ok);
        for (int i = 0; i < LIMIT && n_pulses < n; i++) tick();
        ok = (n_pulses >= n);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) tick();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", o_done); end
        checks++; if (o_tx_signal !== 1'b0) begin failures++; $display("FAIL reset_tx_signal got=%0b exp=0", o_tx_signal); end
        checks++; if (o_tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%0h exp=0", o_tx_byte); end
        checks++; if (o_reg_addr !== 5'd0 || o_mem_addr !== 5'd0) begin
            failures++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", o_reg_addr, o_mem_addr);
        end
        i_reset = 1'b0;
        repeat (3) tick();
        checks++; if (o_busy !== 1'b0 || o_tx_signal !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset busy=%0b sig=%0b exp=0/0", o_busy, o_tx_signal);
        end
    endtask

    task automatic test_full_dump();
        bit ok;
        int sz;
        i_pc = 32'h0000_0024;
        for (int i = 0; i < NREG; i++) reg_model[i] = i * 32'h0101_0101;
        for (int i = 0; i < NMEM; i++) mem_model[i] = 32'hA500_0000 + i;
        build_expected();
        clear_stats();
        start_pulse();
        wait_done(ok);
        repeat (5) tick();
        sz = got_q.size();
        checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=no_done exp=done"); end
        checks++; if (n_pulses != TOTAL) begin failures++; $display("FAIL full_count got=%0d exp=%0d", n_pulses, TOTAL); end
        checks++; if (sz < 12 || {got_q[3], got_q[2], got_q[1], got_q[0]} !== 32'h0000_0024) begin
            failures++; $display("FAIL full_pc_bytes size=%0d exp=24 00 00 00", sz);
        end
        checks++; if (sz < 12 || {got_q[11], got_q[10], got_q[9], got_q[8]} !== 32'h0101_0101) begin
            failures++; $display("FAIL full_reg1_bytes size=%0d exp=01 01 01 01", sz);
        end
        checks++; if (sz < 4 || {got_q[sz-1], got_q[sz-2], got_q[sz-3], got_q[sz-4]} !== 32'hA500_001F) begin
            failures++; $display("FAIL full_last_bytes size=%0d exp=1F 00 00 A5", sz);
        end
        checks++; if (stream_errors() != 0) begin failures++; $display("FAIL full_stream got=%0d_errors exp=0", stream_errors()); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", n_done); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%0b exp=0", o_busy); end
        checks++; if (o_tx_byte !== 8'hA5) begin failures++; $display("FAIL full_byte_hold got=%0h exp=a5", o_tx_byte); end
        checks++; if (stable_err != 0 || proto_err != 0) begin
            failures++; $display("FAIL full_handshake got=%0d/%0d exp=0/0", stable_err, proto_err);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        randomize_state();
        build_expected();
        clear_stats();
        hold_off = 1'b1;
        start_pulse();
        repeat (50) tick();
        checks++; if (n_pulses != 0) begin failures++; $display("FAIL bp_no_pulse got=%0d exp=0", n_pulses); end
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%0b exp=1", o_busy); end
        hold_off = 1'b0;
        tick();
        checks++; if (o_tx_signal !== 1'b1 || o_tx_byte !== i_pc[7:0]) begin
            failures++; $display("FAIL bp_first_byte sig=%0b byte=%0h exp=1/%0h", o_tx_signal, o_tx_byte, i_pc[7:0]);
        end
        wait_done(ok);
        repeat (3) tick();
        checks++; if (!ok || stream_errors() != 0) begin
            failures++; $display("FAIL bp_stream done=%0b errors=%0d exp=1/0", ok, stream_errors());
        end
    endtask

    task automatic test_back_to_back_start();
        bit ok;
        randomize_state();
        build_expected();
        clear_stats();
        start_pulse();
        wait_pulses(100, ok);
        start_pulse();
        wait_done(ok);
        repeat (30) tick();
        checks++; if (n_pulses != TOTAL || n_done != 1) begin
            failures++; $display("FAIL busy_start got=%0d_bytes/%0d_done exp=%0d/1", n_pulses, n_done, TOTAL);
        end
        checks++; if (stream_errors() != 0) begin failures++; $display("FAIL busy_start_stream got=%0d exp=0", stream_errors()); end

        randomize_state();
        build_expected();
        clear_stats();
        i_start = 1'b1;
        tick();
        wait_done(ok);
        repeat (40) tick();
        checks++; if (n_pulses != TOTAL || n_done != 1 || o_busy !== 1'b0) begin
            failures++; $display("FAIL held_start got=%0d/%0d/%0b exp=%0d/1/0", n_pulses, n_done, o_busy, TOTAL);
        end
        i_start = 1'b0;
        repeat (2) tick();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL held_fall_busy got=%0b exp=0", o_busy); end
        randomize_state();
        build_expected();
        clear_stats();
        i_start = 1'b1;
        repeat (2) tick();
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL held_rearm_busy got=%0b exp=1", o_busy); end
        i_start = 1'b0;
        wait_done(ok);
        repeat (3) tick();
        checks++; if (!ok || stream_errors() != 0) begin
            failures++; $display("FAIL held_rearm_stream done=%0b errors=%0d exp=1/0", ok, stream_errors());
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        int saved;
        randomize_state();
        clear_stats();
        start_pulse();
        wait_pulses(37, ok);
        saved = n_pulses;
        i_reset = 1'b1;
        tick();
        checks++; if (o_busy !== 1'b0 || o_tx_signal !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs busy=%0b sig=%0b exp=0/0", o_busy, o_tx_signal);
        end
        tick();
        i_reset = 1'b0;
        repeat (20) tick();
        checks++; if (!ok || n_pulses != saved) begin
            failures++; $display("FAIL midreset_no_more got=%0d exp=%0d", n_pulses, saved);
        end
        randomize_state();
        build_expected();
        clear_stats();
        start_pulse();
        wait_done(ok);
        repeat (3) tick();
        checks++; if (!ok || n_pulses != TOTAL || stream_errors() != 0) begin
            failures++; $display("FAIL midreset_restart bytes=%0d errors=%0d exp=%0d/0", n_pulses, stream_errors(), TOTAL);
        end
    endtask

    task automatic test_spurious_done();
        bit ok;
        randomize_state();
        build_expected();
        clear_stats();
        spur_force = 1'b1;
        repeat (3) tick();
        spur_force = 1'b0;
        spur_en = 1'b1;
        start_pulse();
        wait_done(ok);
        repeat (10) tick();
        spur_en = 1'b0;
        checks++; if (spur_count == 0) begin failures++; $display("FAIL spur_injected got=0 exp=nonzero"); end
        checks++; if (!ok || n_pulses != TOTAL || n_done != 1) begin
            failures++; $display("FAIL spur_count got=%0d/%0d exp=%0d/1", n_pulses, n_done, TOTAL);
        end
        checks++; if (stream_errors() != 0) begin failures++; $display("FAIL spur_stream got=%0d exp=0", stream_errors()); end
    endtask

    task automatic test_mem_latency();
        bit ok;
        int merr;
        randomize_state();
        build_expected();
        clear_stats();
        start_pulse();
        wait_done(ok);
        repeat (3) tick();
        merr = 0;
        for (int i = 4 * (1 + NREG); i < TOTAL; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) merr++;
        checks++; if (!ok || merr != 0) begin failures++; $display("FAIL mem_words done=%0b errors=%0d exp=1/0", ok, merr); end
        checks++; if (addr_err != 0) begin failures++; $display("FAIL mem_addr_stable got=%0d exp=0", addr_err); end
        checks++; if (seq_err != 0) begin failures++; $display("FAIL addr_sequence got=%0d exp=0", seq_err); end
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_pc = '0;
        hold_off = 1'b0; spur_force = 1'b0; spur_en = 1'b0;
        for (int i = 0; i < NREG; i++) reg_model[i] = '0;
        for (int i = 0; i < NMEM; i++) mem_model[i] = '0;
        clear_stats();
        test_reset();
        test_full_dump();
        test_backpressure();
        test_back_to_back_start();
        test_reset_mid_dump();
        test_spurious_done();
        test_mem_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
